// File: rtl/ext_int_pkg.sv
// Shared types and constants for the external interrupt controller.
package ext_int_pkg;

  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_TRIGGER = 2'd3;

  function automatic logic [7:0] status_word(input state_t s, input logic req,
                                             input logic [VEC_W-1:0] vec);
    return {s, req, 2'b00, vec};
  endfunction

endpackage

// File: rtl/ext_int_if.sv
// CPU-facing config port and irq handshake, plus debug taps of FSM state and synchronised pins.
interface ext_int_if
  import ext_int_pkg::*;
#(
  parameter int NUM_LINES = 3
);
  logic                 cfgWe;
  logic [1:0]           cfgAddr;
  logic [7:0]           cfgWdata;
  logic [7:0]           cfgRdata;
  // irqReq is held while a request is outstanding; a one-cycle irqAck accepts it,
  // a later one-cycle irqDone ends service. Pulses outside those phases are ignored.
  logic                 irqReq;
  logic [VEC_W-1:0]     irqVector;
  logic                 irqAck;
  logic                 irqDone;
  state_t               dbgState;
  logic [NUM_LINES-1:0] dbgLevel;

  modport master (
    output cfgWe, cfgAddr, cfgWdata, irqAck, irqDone,
    input  cfgRdata, irqReq, irqVector, dbgState, dbgLevel
  );

  modport slave (
    input  cfgWe, cfgAddr, cfgWdata, irqAck, irqDone,
    output cfgRdata, irqReq, irqVector, dbgState, dbgLevel
  );

endinterface

// File: rtl/ext_int_sync.sv
// Per-line synchroniser chain followed by a previous-value register for rising-edge detection.
module ext_int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/ext_int_controller.sv
// Fixed-priority external interrupt controller with req/ack/done sequencing to the CPU.
// Define EXTINT_LEVEL_TRIGGER_EN to add the per-line level-trigger register at address 3.
module ext_int_controller
  import ext_int_pkg::*;
#(
  parameter int NUM_LINES   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 boardClk,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] extInt,
  ext_int_if.slave             bus
);

  logic [NUM_LINES-1:0] w_level;
  logic [NUM_LINES-1:0] w_rise;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    ext_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (boardClk),
      .rst     (reset),
      .i_async (extInt[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [VEC_W-1:0]     r_vector;
  logic [VEC_W-1:0]     w_vector_nxt;
  logic [NUM_LINES-1:0] r_enable;
  logic [NUM_LINES-1:0] w_enable_nxt;
  logic [NUM_LINES-1:0] r_pending;
  logic [NUM_LINES-1:0] w_pending_nxt;
  logic [NUM_LINES-1:0] w_elig;
  logic [NUM_LINES-1:0] w_vec_oh;
  logic [NUM_LINES-1:0] w_ack_clr;
  logic [NUM_LINES-1:0] w_w1c;
  logic [VEC_W-1:0]     w_winner;
  logic                 w_we_enable;
  logic                 w_we_pending;
  logic                 w_req;
  logic [7:0]           w_rdata;
  logic                 w_unused_wdata;

  assign w_we_enable    = bus.cfgWe && (bus.cfgAddr == ADDR_ENABLE);
  assign w_we_pending   = bus.cfgWe && (bus.cfgAddr == ADDR_PENDING);
  assign w_enable_nxt   = w_we_enable ? bus.cfgWdata[NUM_LINES-1:0] : r_enable;
  assign w_elig         = r_pending & r_enable;
  assign w_req          = (r_state == REQ);
  assign w_unused_wdata = ^bus.cfgWdata;

  always_comb begin
    w_winner = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (w_elig[i]) w_winner = VEC_W'(i);
    end
  end

  always_comb begin
    w_vec_oh = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      w_vec_oh[i] = (r_vector == VEC_W'(i));
    end
  end

  assign w_ack_clr = (w_req && bus.irqAck) ? w_vec_oh : '0;
  assign w_w1c     = w_we_pending ? bus.cfgWdata[NUM_LINES-1:0] : '0;

`ifdef EXTINT_LEVEL_TRIGGER_EN
  logic [NUM_LINES-1:0] r_trigger;
  logic                 w_we_trigger;

  assign w_we_trigger = bus.cfgWe && (bus.cfgAddr == ADDR_TRIGGER);

  always_ff @(posedge boardClk or posedge reset) begin
    if (reset) r_trigger <= '0;
    else if (w_we_trigger) r_trigger <= bus.cfgWdata[NUM_LINES-1:0];
  end

  // Level lines mirror the synchronised pin, so neither ack nor W1C can clear them while it is high.
  always_comb begin
    w_pending_nxt = w_rise | (r_pending & ~(w_ack_clr | w_w1c));
    w_pending_nxt = (w_pending_nxt & ~r_trigger) | (w_level & r_trigger);
  end
`else
  // A new edge overrides a same-cycle clear.
  always_comb begin
    w_pending_nxt = w_rise | (r_pending & ~(w_ack_clr | w_w1c));
  end
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_vector_nxt = r_vector;
    case (r_state)
      IDLE: begin
        if (|w_elig) begin
          w_state_nxt  = REQ;
          w_vector_nxt = w_winner;
        end
      end
      REQ: begin
        if (bus.irqAck) w_state_nxt = SERVICE;
        else if (~|(w_enable_nxt & w_vec_oh)) w_state_nxt = IDLE;
      end
      SERVICE: begin
        if (bus.irqDone) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge boardClk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_vector  <= '0;
      r_enable  <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_vector  <= w_vector_nxt;
      r_enable  <= w_enable_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.cfgAddr)
      ADDR_ENABLE:  w_rdata[NUM_LINES-1:0] = r_enable;
      ADDR_PENDING: w_rdata[NUM_LINES-1:0] = r_pending;
      ADDR_STATUS:  w_rdata = status_word(r_state, w_req, r_vector);
      default: begin
`ifdef EXTINT_LEVEL_TRIGGER_EN
        w_rdata[NUM_LINES-1:0] = r_trigger;
`else
        w_rdata = '0;
`endif
      end
    endcase
  end

  assign bus.cfgRdata  = w_rdata;
  assign bus.irqReq    = w_req;
  assign bus.irqVector = r_vector;
  assign bus.dbgState  = r_state;
  assign bus.dbgLevel  = w_level;

endmodule

// File: tb/tb_ext_int_controller.sv
// Randomised and directed bench: expected request vectors are queued from a line/enable priority model.
module tb_ext_int_controller;
  import ext_int_pkg::*;

  localparam int NL = 3;
  localparam int SS = 2;

  logic          boardClk = 1'b0;
  logic          reset    = 1'b1;
  logic [NL-1:0] ext_int  = '0;

  ext_int_if #(.NUM_LINES(NL)) bus ();

  ext_int_controller #(.NUM_LINES(NL), .SYNC_STAGES(SS)) dut (
    .boardClk (boardClk),
    .reset    (reset),
    .extInt   (ext_int),
    .bus      (bus)
  );

  // clock / reset
  always #5 boardClk = ~boardClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [VEC_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic mon_prev_req = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every new request must match the head of the expected queue
  always @(negedge boardClk) begin
    if (bus.irqReq && !mon_prev_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req: got vector %0d expected no request at %0t", bus.irqVector, $time);
      end else begin
        logic [VEC_W-1:0] e;
        e = exp_q.pop_front();
        if (bus.irqVector !== e) begin
          errors++;
          $display("FAIL req_vector: got %0d expected %0d at %0t", bus.irqVector, e, $time);
        end
      end
    end
    mon_prev_req = bus.irqReq;
  end

  // driver tasks
  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge boardClk); #1;
    bus.cfgWe = 1'b1; bus.cfgAddr = a; bus.cfgWdata = d;
    @(posedge boardClk); #1;
    bus.cfgWe = 1'b0; bus.cfgWdata = '0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [7:0] d);
    bus.cfgAddr = a;
    @(negedge boardClk);
    d = bus.cfgRdata;
  endtask

  task automatic pulse_ack();
    @(posedge boardClk); #1; bus.irqAck = 1'b1;
    @(posedge boardClk); #1; bus.irqAck = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge boardClk); #1; bus.irqDone = 1'b1;
    @(posedge boardClk); #1; bus.irqDone = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    @(negedge boardClk);
    while (!bus.irqReq && n < budget) begin
      @(negedge boardClk);
      n++;
    end
    checks++;
    if (!bus.irqReq) begin
      errors++;
      $display("FAIL wait_req: got irqReq 0 expected 1 within %0d cycles at %0t", budget, $time);
    end
  endtask

  task automatic idle_watch(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge boardClk);
      seen = seen | bus.irqReq;
    end
    check(name, {7'd0, seen}, 8'h00);
  endtask

  task automatic lower_pins();
    @(posedge boardClk); #1;
    ext_int = '0;
    repeat (SS + 3) @(posedge boardClk);
    #1;
  endtask

  task automatic raise_pins(input logic [NL-1:0] p);
    @(posedge boardClk); #1;
    ext_int = p;
  endtask

  logic [7:0] rd;

  initial begin
    bus.cfgWe = 1'b0; bus.cfgAddr = ADDR_STATUS; bus.cfgWdata = '0;
    bus.irqAck = 1'b0; bus.irqDone = 1'b0;

    // reset state
    repeat (3) @(posedge boardClk);
    #1 reset = 1'b0;
    cfg_read(ADDR_STATUS, rd);  check("reset_status", rd, 8'h00);
    cfg_read(ADDR_ENABLE, rd);  check("reset_enable", rd, 8'h00);
    cfg_read(ADDR_PENDING, rd); check("reset_pending", rd, 8'h00);
    check("reset_irqreq", {7'd0, bus.irqReq}, 8'h00);

    // basic flow with edge-3 pending timing
    cfg_write(ADDR_ENABLE, 8'h07);
    cfg_read(ADDR_ENABLE, rd); check("enable_rw", rd, 8'h07);
    bus.cfgAddr = ADDR_PENDING;
    exp_q.push_back(3'd1);
    raise_pins(3'b010);
    repeat (3) @(negedge boardClk);
    check("pending_before_edge3", bus.cfgRdata, 8'h00);
    @(negedge boardClk);
    check("pending_at_edge3", bus.cfgRdata, 8'h02);
    check("req_not_yet", {7'd0, bus.irqReq}, 8'h00);
    @(negedge boardClk);
    check("req_after_edge3", {7'd0, bus.irqReq}, 8'h01);
    pulse_ack();
    @(negedge boardClk);
    check("req_after_ack", {7'd0, bus.irqReq}, 8'h00);
    check("pending_after_ack", bus.cfgRdata, 8'h00);
    cfg_read(ADDR_STATUS, rd); check("status_service", rd, 8'h81);
    pulse_done();
    cfg_read(ADDR_STATUS, rd); check("status_idle", rd, 8'h01);
    lower_pins();

    // priority: lines 1 and 2 together
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    raise_pins(3'b110);
    wait_req(20);
    pulse_ack();
    pulse_done();
    @(negedge boardClk);
    check("idle_gap", {7'd0, bus.irqReq}, 8'h00);
    @(negedge boardClk);
    check("second_req", {7'd0, bus.irqReq}, 8'h01);
    pulse_ack();
    pulse_done();
    lower_pins();

    // mask withdrawal and resume
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd2);
    raise_pins(3'b100);
    wait_req(20);
    cfg_write(ADDR_ENABLE, 8'h03);
    @(negedge boardClk);
    check("withdraw_req", {7'd0, bus.irqReq}, 8'h00);
    cfg_read(ADDR_PENDING, rd); check("withdraw_pending", rd, 8'h04);
    cfg_write(ADDR_ENABLE, 8'h07);
    wait_req(10);
    pulse_ack();
    pulse_done();
    lower_pins();

    // set wins over a same-cycle W1C
    cfg_write(ADDR_ENABLE, 8'h00);
    raise_pins(3'b001);
    @(posedge boardClk); #1;
    @(posedge boardClk); #1;
    bus.cfgWe = 1'b1; bus.cfgAddr = ADDR_PENDING; bus.cfgWdata = 8'h01;
    @(posedge boardClk); #1;
    bus.cfgWe = 1'b0; bus.cfgWdata = '0;
    cfg_read(ADDR_PENDING, rd); check("set_wins", rd, 8'h01);
    cfg_write(ADDR_PENDING, 8'h01);
    cfg_read(ADDR_PENDING, rd); check("w1c_clears", rd, 8'h00);
    lower_pins();

    // reset in the middle of a request
    cfg_write(ADDR_ENABLE, 8'h07);
    exp_q.push_back(3'd0);
    raise_pins(3'b001);
    wait_req(20);
    @(posedge boardClk); #1;
    reset = 1'b1;
    #1;
    check("rst_irqreq", {7'd0, bus.irqReq}, 8'h00);
    check("rst_vector", {5'd0, bus.irqVector}, 8'h00);
    bus.cfgAddr = ADDR_ENABLE;  #1; check("rst_enable", bus.cfgRdata, 8'h00);
    bus.cfgAddr = ADDR_PENDING; #1; check("rst_pending", bus.cfgRdata, 8'h00);
    @(posedge boardClk); #1;
    reset = 1'b0;
    idle_watch("no_req_after_reset", 12);
    lower_pins();
    cfg_write(ADDR_PENDING, 8'hFF);

`ifdef EXTINT_LEVEL_TRIGGER_EN
    // level-triggered line re-requests while held
    cfg_write(ADDR_TRIGGER, 8'h01);
    cfg_read(ADDR_TRIGGER, rd); check("trigger_rw", rd, 8'h01);
    cfg_write(ADDR_ENABLE, 8'h01);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd0);
    raise_pins(3'b001);
    wait_req(20);
    pulse_ack();
    cfg_read(ADDR_PENDING, rd); check("level_pending_after_ack", rd, 8'h01);
    pulse_done();
    wait_req(10);
    @(posedge boardClk); #1;
    ext_int = '0;
    repeat (SS + 3) @(posedge boardClk);
    pulse_ack();
    pulse_done();
    idle_watch("level_no_third_req", 10);
    cfg_write(ADDR_TRIGGER, 8'h00);
`else
    // edge-only build: addr 3 reads zero, a held pin requests once
    cfg_write(ADDR_TRIGGER, 8'hFF);
    cfg_read(ADDR_TRIGGER, rd); check("trigger_absent", rd, 8'h00);
    cfg_write(ADDR_ENABLE, 8'h01);
    exp_q.push_back(3'd0);
    raise_pins(3'b001);
    wait_req(20);
    pulse_ack();
    pulse_done();
    idle_watch("edge_single_req", 10);
`endif
    lower_pins();
    cfg_write(ADDR_PENDING, 8'hFF);

    // randomised episodes against the priority model
    for (int ep = 0; ep < 25; ep++) begin
      logic [NL-1:0] en, lines, served;
      int n;
      en    = NL'($urandom_range(0, 7));
      lines = NL'($urandom_range(1, 7));
      served = lines & en;
      n = 0;
      for (int i = 0; i < NL; i++) begin
        if (served[i]) begin
          exp_q.push_back(VEC_W'(i));
          n++;
        end
      end
      cfg_write(ADDR_ENABLE, {5'd0, en});
      raise_pins(lines);
      for (int k = 0; k < n; k++) begin
        wait_req(20);
        repeat ($urandom_range(0, 3)) @(posedge boardClk);
        pulse_ack();
        repeat ($urandom_range(0, 4)) @(posedge boardClk);
        pulse_done();
      end
      idle_watch("rand_no_extra_req", 8);
      lower_pins();
      cfg_read(ADDR_PENDING, rd);
      check("rand_leftover_pending", rd, {5'd0, lines & ~en});
      cfg_write(ADDR_PENDING, 8'hFF);
    end

    check("exp_q_drained", 8'(exp_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
